// File: rtl/pwm_capture_if.sv
// ============================================================================
// pwm_capture_if : PWM input and measurement result bundle for pwm_capture
// Rev 1.0
// ============================================================================
`default_nettype none

interface pwm_capture_if #(
   parameter int CNT_W = 27
) ();
   logic             pwm_in;
   logic             meas_valid;
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] high_cnt;
   logic [6:0]       duty;
   logic             stuck;
   logic             overrun;

   modport master (
      output pwm_in,
      input  meas_valid, period_cnt, high_cnt, duty, stuck, overrun
   );

   modport slave (
      input  pwm_in,
      output meas_valid, period_cnt, high_cnt, duty, stuck, overrun
   );
endinterface

`default_nettype wire

// File: rtl/pwm_capture.sv
// ============================================================================
// pwm_capture : measures PWM period, high time and rounded duty; flags stuck line
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_capture #(
   parameter int SYS_FREQ   = 125,
   parameter int CNT_W      = 27,
   parameter int TIMEOUT_MS = 100
) (
   input  logic         clk,
   input  logic         reset_n,
   pwm_capture_if.slave bus
);

   localparam int               NW     = CNT_W + 7;
   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(SYS_FREQ * 1000 * TIMEOUT_MS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEAS = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic             r_sync1;
   logic             r_sync2;
   logic             r_s_d;
   logic             w_rise;
   logic             w_fall;

   logic [CNT_W-1:0] r_cnt;
   logic             r_armed;
   logic [CNT_W-1:0] r_hi_lat;
   logic [CNT_W-1:0] r_p;
   logic [CNT_W-1:0] r_h;

   logic [NW-1:0]    r_rem;
   logic [NW-1:0]    r_dsh;
   logic [5:0]       r_q;
   logic [2:0]       r_iter;

   logic             r_meas_valid;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_high;
   logic [6:0]       r_duty;
   logic             r_stuck;
   logic             r_overrun;

   logic             w_timeout;
   logic             w_latch;
   logic             w_step;
   logic             w_done;
   logic             w_drop;
   logic [NW-1:0]    w_n;
   logic             w_ge;
   logic [6:0]       w_q_fin;

   assign w_rise    = r_sync2 & ~r_s_d;
   assign w_fall    = ~r_sync2 & r_s_d;
   // A rise in the same cycle always takes precedence over the timeout.
   assign w_timeout = r_armed && (r_cnt >= TO_CNT) && !w_rise;

   // Rounded dividend: H*100 + P/2, sized so nothing is lost for any CNT_W.
   assign w_n     = (NW'(r_hi_lat) * NW'(100)) + NW'(r_cnt >> 1);
   assign w_ge    = (r_rem >= r_dsh);
   assign w_q_fin = {r_q, w_ge};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_s_d   <= 1'b0;
      end else begin
         r_sync1 <= bus.pwm_in;
         r_sync2 <= r_sync1;
         r_s_d   <= r_sync2;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_armed  <= 1'b1;
         r_hi_lat <= '0;
      end else begin
         if (w_rise) begin
            r_cnt <= CNT_W'(1);
         end else if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         if (w_rise) begin
            r_armed <= 1'b1;
         end else if (w_timeout) begin
            r_armed <= 1'b0;
         end

         if (w_fall) begin
            r_hi_lat <= r_cnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_step      = 1'b0;
      w_done      = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_state_nxt = ST_MEAS;
            end
         end
         ST_MEAS: begin
            if (w_rise) begin
               w_latch     = 1'b1;
               w_state_nxt = ST_DIV;
            end
         end
         ST_DIV: begin
            w_step = 1'b1;
            w_drop = w_rise;
            if (r_iter == 3'd6) begin
               w_done      = 1'b1;
               w_state_nxt = ST_MEAS;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (w_timeout) begin
         w_state_nxt = ST_IDLE;
         w_latch     = 1'b0;
         w_step      = 1'b0;
         w_done      = 1'b0;
      end
   end

   // Restoring divider: divisor pre-shifted by 6, one quotient bit per cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_p    <= '0;
         r_h    <= '0;
         r_rem  <= '0;
         r_dsh  <= '0;
         r_q    <= '0;
         r_iter <= '0;
      end else if (w_latch) begin
         r_p    <= r_cnt;
         r_h    <= r_hi_lat;
         r_rem  <= w_n;
         r_dsh  <= NW'(r_cnt) << 6;
         r_q    <= '0;
         r_iter <= '0;
      end else if (w_step) begin
         if (w_ge) begin
            r_rem <= r_rem - r_dsh;
         end
         r_dsh  <= r_dsh >> 1;
         r_q    <= {r_q[4:0], w_ge};
         r_iter <= r_iter + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_meas_valid <= 1'b0;
         r_period     <= '0;
         r_high       <= '0;
         r_duty       <= '0;
         r_stuck      <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_meas_valid <= 1'b0;
         if (w_done) begin
            r_meas_valid <= 1'b1;
            r_period     <= r_p;
            r_high       <= r_h;
            r_duty       <= (w_q_fin > 7'd100) ? 7'd100 : w_q_fin;
            r_stuck      <= 1'b0;
         end else if (w_timeout) begin
            r_meas_valid <= 1'b1;
            r_period     <= '0;
            r_high       <= '0;
            r_duty       <= r_sync2 ? 7'd100 : 7'd0;
            r_stuck      <= 1'b1;
         end
         if (w_drop) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign bus.meas_valid = r_meas_valid;
   assign bus.period_cnt = r_period;
   assign bus.high_cnt   = r_high;
   assign bus.duty       = r_duty;
   assign bus.stuck      = r_stuck;
   assign bus.overrun    = r_overrun;

endmodule

`default_nettype wire
